// File: rtl/screen_ctrl_if.sv
// vga_if: raster timing bundle shared by the VGA path.
// Fields: vblank (1 while the raster is in vertical blank).
interface vga_if;
  logic vblank;

  modport in (input vblank);
endinterface

// File: rtl/screen_ctrl.sv
// screen_ctrl: START/PLAY/OVER screen sequencer and layer compositor.
// Ports: clk, rst (sync, active-high), vin (vga_if.in, uses vblank),
//   start_btn/collision/pause_btn pulses, start/game/over rgb+valid
//   layers; outputs state, game_en, game_rst, frame_tick, rgb.
// Optional: define SCREEN_PAUSE_EN to add the PAUSE screen (state 3).
module screen_ctrl #(
  parameter int          HOLD_FRAMES = 60,
  parameter logic [11:0] BG_RGB      = 12'h4CF
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vin,
  input  logic        start_btn,
  input  logic        collision,
  input  logic [11:0] start_rgb,
  input  logic        start_valid,
  input  logic [11:0] game_rgb,
  input  logic        game_valid,
  input  logic [11:0] over_rgb,
  input  logic        over_valid,
  input  logic        pause_btn,
  output logic [1:0]  state,
  output logic        game_en,
  output logic        game_rst,
  output logic        frame_tick,
  output logic [11:0] rgb
);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam int HW =
    (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  logic [1:0]    r_state;
  logic          r_vb_prev;
  logic          r_start_pend;
  logic          r_coll_pend;
  logic [HW-1:0] r_hold;
  logic          r_game_en;
  logic          r_game_rst;
  logic          r_frame_tick;
  logic [11:0]   r_rgb;

  logic          w_boundary;
  logic [1:0]    w_state_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_start_ok;
  logic          w_coll_ok;
  logic [11:0]   w_rgb;

`ifdef SCREEN_PAUSE_EN
  logic r_pause_pend;
  logic w_pause_ok;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_btn;
`endif

  // Rising edge of vblank marks the start of a frame boundary.
  assign w_boundary = vin.vblank & ~r_vb_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (w_boundary) begin
      case (r_state)
        ST_START: begin
          if (r_start_pend) w_state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          // Collision beats a simultaneous pause request.
          if (r_coll_pend) begin
            w_state_nxt = ST_OVER;
            w_hold_nxt  = '0;
          end
`ifdef SCREEN_PAUSE_EN
          else if (r_pause_pend) begin
            w_state_nxt = ST_PAUSE;
          end
`endif
        end
        ST_OVER: begin
          if (r_hold != HOLD_MAX) w_hold_nxt = r_hold + 1'b1;
          if (r_start_pend) w_state_nxt = ST_START;
        end
`ifdef SCREEN_PAUSE_EN
        ST_PAUSE: begin
          if (r_pause_pend) w_state_nxt = ST_PLAY;
        end
`endif
        default: w_state_nxt = ST_START;
      endcase
    end
  end

  // Eligibility follows the state/hold that will hold after this edge,
  // so a pulse landing on a boundary is judged by the new screen.
  assign w_start_ok = (w_state_nxt == ST_START) ||
                      ((w_state_nxt == ST_OVER) &&
                       (w_hold_nxt == HOLD_MAX));
  assign w_coll_ok  = (w_state_nxt == ST_PLAY);

`ifdef SCREEN_PAUSE_EN
  assign w_pause_ok = (w_state_nxt == ST_PLAY) ||
                      (w_state_nxt == ST_PAUSE);
`endif

  // Compositing uses the registered state, so a change made on one
  // edge shows from the pixel sampled on the next edge.
  always_comb begin
    w_rgb = BG_RGB;
    case (r_state)
      ST_START: w_rgb = start_valid ? start_rgb : BG_RGB;
      ST_PLAY:  w_rgb = game_valid  ? game_rgb  : BG_RGB;
      ST_OVER, ST_PAUSE: begin
        if (over_valid)      w_rgb = over_rgb;
        else if (game_valid) w_rgb = game_rgb;
        else                 w_rgb = BG_RGB;
      end
      default:  w_rgb = BG_RGB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_START;
      r_vb_prev    <= 1'b0;
      r_start_pend <= 1'b0;
      r_coll_pend  <= 1'b0;
      r_hold       <= '0;
      r_game_en    <= 1'b0;
      r_game_rst   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_rgb        <= 12'h000;
`ifdef SCREEN_PAUSE_EN
      r_pause_pend <= 1'b0;
`endif
    end else begin
      r_vb_prev    <= vin.vblank;
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_game_en    <= (w_state_nxt == ST_PLAY);
      r_game_rst   <= w_boundary & r_start_pend &
                      (r_state == ST_START);
      r_frame_tick <= w_boundary;
      r_rgb        <= w_rgb;
      // Every boundary consumes the old flags; a pulse on the same
      // cycle survives for the following boundary.
      r_start_pend <= (r_start_pend & ~w_boundary) |
                      (start_btn & w_start_ok);
      r_coll_pend  <= (r_coll_pend & ~w_boundary) |
                      (collision & w_coll_ok);
`ifdef SCREEN_PAUSE_EN
      r_pause_pend <= (r_pause_pend & ~w_boundary) |
                      (pause_btn & w_pause_ok);
`endif
    end
  end

  assign state      = r_state;
  assign game_en    = r_game_en;
  assign game_rst   = r_game_rst;
  assign frame_tick = r_frame_tick;
  assign rgb        = r_rgb;

endmodule

// File: tb/tb_screen_ctrl.sv
// tb_screen_ctrl: directed scoreboard bench for screen_ctrl.
// Expectations are queued with a target cycle; a monitor checks them.
module tb_screen_ctrl;

  localparam int FRAME    = 40;
  localparam int VB_START = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, collision, pause_btn;
  logic [11:0] start_rgb, game_rgb, over_rgb;
  logic        start_valid, game_valid, over_valid;
  logic [1:0]  state;
  logic        game_en, game_rst, frame_tick;
  logic [11:0] rgb;

  vga_if vif ();

  screen_ctrl #(.HOLD_FRAMES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .vin        (vif),
    .start_btn  (start_btn),
    .collision  (collision),
    .start_rgb  (start_rgb),
    .start_valid(start_valid),
    .game_rgb   (game_rgb),
    .game_valid (game_valid),
    .over_rgb   (over_rgb),
    .over_valid (over_valid),
    .pause_btn  (pause_btn),
    .state      (state),
    .game_en    (game_en),
    .game_rst   (game_rst),
    .frame_tick (frame_tick),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    string       nm;
    logic [1:0]  st;
    logic        en;
    logic        gr;
    logic        ft;
    logic [11:0] px;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit   ok;
  int   cyc = 0;
  int   pos = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      ok = (e.at == cyc) && (state === e.st) && (game_en === e.en) &&
           (game_rst === e.gr) && (frame_tick === e.ft) &&
           (rgb === e.px);
      if (!ok) begin
        n_bad++;
        $display("FAIL %s @%0d: got st=%0d en=%b grst=%b ft=%b rgb=%03h, want st=%0d en=%b grst=%b ft=%b rgb=%03h (due %0d)",
                 e.nm, cyc, state, game_en, game_rst, frame_tick, rgb,
                 e.st, e.en, e.gr, e.ft, e.px, e.at);
      end
    end
  end

  task automatic push(input int at, input string nm, input logic [1:0] st,
                      input logic en, input logic gr, input logic ft,
                      input logic [11:0] px);
    exp_t x;
    x.at = at; x.nm = nm; x.st = st; x.en = en;
    x.gr = gr; x.ft = ft; x.px = px;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
    vif.vblank = (pos >= VB_START);
    start_btn = 1'b0;
    collision = 1'b0;
    pause_btn = 1'b0;
  endtask

  // Returns with vblank just raised; the boundary edge is the next one.
  task automatic wait_bnd(output int b);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (pos != VB_START && n < 2 * FRAME);
    if (pos != VB_START) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_bnd: got no vblank rise, want one");
    end
    b = cyc + 1;
  endtask

  task automatic step_to(input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (pos != p && n < 2 * FRAME);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_btn = 0; collision = 0; pause_btn = 0;
    start_rgb = 0; game_rgb = 0; over_rgb = 0;
    start_valid = 0; game_valid = 0; over_valid = 0;
    vif.vblank = 1'b0;
    step();
    step();
    push(cyc, "reset", 2'd0, 0, 0, 0, 12'h000);
    rst = 1'b0;

    game_valid = 1; game_rgb = 12'h123;
    push(cyc + 1, "start_bg", 2'd0, 0, 0, 0, 12'h4CF);
    step();
    start_valid = 1; start_rgb = 12'h0F0;
    push(cyc + 1, "start_fg", 2'd0, 0, 0, 0, 12'h0F0);
    step();
    start_valid = 0; game_valid = 0;

    step_to(10);
    start_btn = 1;
    push(cyc + 3, "start_held", 2'd0, 0, 0, 0, 12'h4CF);
    step();
    wait_bnd(bc);
    push(bc, "play_enter", 2'd1, 1, 1, 1, 12'h4CF);
    push(bc + 1, "grst_1cyc", 2'd1, 1, 0, 0, 12'h4CF);
    step();
    step();

    game_valid = 1; game_rgb = 12'h0A5;
    over_valid = 1; over_rgb = 12'hF00;
    push(cyc + 1, "play_game", 2'd1, 1, 0, 0, 12'h0A5);
    step();
    game_valid = 0;
    push(cyc + 1, "play_bg", 2'd1, 1, 0, 0, 12'h4CF);
    step();
    over_valid = 0;

    step_to(10);
    collision = 1;
    push(cyc + 1, "coll_wait", 2'd1, 1, 0, 0, 12'h4CF);
    step();
    wait_bnd(bc);
    over_valid = 1; over_rgb = 12'hF00;
    push(bc, "over_enter", 2'd2, 0, 0, 1, 12'h4CF);
    push(bc + 1, "over_banner", 2'd2, 0, 0, 0, 12'hF00);
    step();
    step();
    over_valid = 0; game_valid = 1; game_rgb = 12'h0A5;
    push(cyc + 1, "over_scene", 2'd2, 0, 0, 0, 12'h0A5);
    step();
    game_valid = 0;

    for (int i = 0; i < 2; i++) begin
      wait_bnd(bc);
      step();
    end
    start_btn = 1;
    step();
    wait_bnd(bc);
    push(bc, "hold_ignore", 2'd2, 0, 0, 1, 12'h4CF);
    step();
    wait_bnd(bc);
    step();
    start_btn = 1;
    step();
    wait_bnd(bc);
    push(bc, "over_exit", 2'd0, 0, 0, 1, 12'h4CF);
    step();

    start_btn = 1;
    step();
    wait_bnd(bc);
    step();
    collision = 1;
    step();
    wait_bnd(bc);
    step();
    for (int i = 0; i < 4; i++) begin
      wait_bnd(bc);
      step();
    end
    start_btn = 1;
    step();
    step_to(5);
    rst = 1'b1;
    push(cyc + 1, "rst_over", 2'd0, 0, 0, 0, 12'h000);
    step();
    rst = 1'b0;
    wait_bnd(bc);
    start_btn = 1;
    push(bc, "rst_no_trans", 2'd0, 0, 0, 1, 12'h4CF);
    step();
    wait_bnd(bc);
    push(bc, "bnd_press_kept", 2'd1, 1, 1, 1, 12'h4CF);
    step();
    step();

`ifdef SCREEN_PAUSE_EN
    pause_btn = 1;
    step();
    wait_bnd(bc);
    push(bc, "pause_enter", 2'd3, 0, 0, 1, 12'h4CF);
    step();
    step();
    over_valid = 1; over_rgb = 12'h0FF;
    game_valid = 1; game_rgb = 12'h0A5;
    push(cyc + 1, "pause_banner", 2'd3, 0, 0, 0, 12'h0FF);
    step();
    over_valid = 0;
    push(cyc + 1, "pause_scene", 2'd3, 0, 0, 0, 12'h0A5);
    step();
    game_valid = 0;
    pause_btn = 1;
    step();
    wait_bnd(bc);
    push(bc, "pause_exit", 2'd1, 1, 0, 1, 12'h4CF);
    step();
    step();
    pause_btn = 1;
    collision = 1;
    step();
    wait_bnd(bc);
    push(bc, "coll_wins", 2'd2, 0, 0, 1, 12'h4CF);
    step();
`else
    pause_btn = 1;
    step();
    wait_bnd(bc);
    push(bc, "pause_ignored", 2'd1, 1, 0, 1, 12'h4CF);
    step();
`endif

    step();
    step();
    step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/screen_ctrl.md
Name: screen_ctrl

Overview:
Game-screen sequencer and pixel compositor for the VGA path.
- Runs the START -> PLAY -> OVER -> START screen FSM.
- Applies every state change only on a frame boundary, so no screen ever tears mid-frame.
- Gates and priority-muxes the rgb/valid pairs from the start-screen, game-scene and game-over draw layers into one registered pixel stream.

Parameters:
- HOLD_FRAMES, 60, minimum frames spent in OVER before a start press is accepted.
- BG_RGB, 12'h4CF, background colour driven when no enabled layer is valid.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  reset; synchronous, active-high
- vin  vga_if.in  -  timing bundle; fields used: vblank (1 during vertical blank)
- start_btn  in  1  single-cycle start/flap press pulse, already synchronised
- collision  in  1  single-cycle pulse from game logic; bird hit pipe/ground
- start_rgb  in  12  start-screen layer colour
- start_valid  in  1  start-screen layer pixel valid
- game_rgb  in  12  game-scene layer colour (bird, pipes)
- game_valid  in  1  game-scene layer pixel valid
- over_rgb  in  12  game-over layer colour
- over_valid  in  1  game-over layer pixel valid
- pause_btn  in  1  single-cycle pulse; used only with SCREEN_PAUSE_EN
- state  out  2  current screen: 0=START, 1=PLAY, 2=OVER, 3=PAUSE
- game_en  out  1  high while game logic may advance (state==PLAY)
- game_rst  out  1  one-cycle pulse on each START->PLAY transition
- frame_tick  out  1  one-cycle pulse on each frame boundary
- rgb  out  12  composited pixel colour, registered

Behaviour:
- Reset values: state=START, game_en=0, game_rst=0, frame_tick=0, rgb=12'h000.
- Reset also clears: pending flags, hold counter, vblank history.
- Reset mid-frame or mid-OVER returns to START immediately; no boundary wait.
- Frame boundary: cycle where vin.vblank==1 and the registered previous vblank==0. frame_tick is registered, so it is high the following cycle.
- Event latching:
  - start_btn sets start_pend.
  - collision sets coll_pend.
  - Pending flags are held until consumed at a boundary, then cleared in the same cycle.
- Pulses arriving on the boundary cycle itself are not lost; they are kept for the next boundary.
- Every state change is applied at a boundary; both pending flags clear on any transition.
- START:
  - start_pend -> PLAY; game_rst=1 for exactly one cycle, coincident with state becoming PLAY.
  - collision is ignored and not latched.
- PLAY:
  - coll_pend -> OVER; hold counter loads 0.
  - start_btn is ignored and not latched (flap handled by game logic).
- OVER:
  - Hold counter increments on each boundary and saturates at HOLD_FRAMES.
  - start_btn is latched only while hold==HOLD_FRAMES; earlier presses are discarded.
  - start_pend -> START.
- game_en = (state==PLAY), registered together with state.
- Compositing, one-cycle registered latency from the layer inputs:
  - START: start_valid ? start_rgb : BG_RGB.
  - PLAY: game_valid ? game_rgb : BG_RGB.
  - OVER: over_valid ? over_rgb : game_valid ? game_rgb : BG_RGB. The frozen scene shows behind the banner.
- The compositor does not blank. Downstream delays vin by one stage and applies blanking.
- State-change pixel rule: a state change registered on cycle N affects compositing from the pixel sampled on cycle N+1.

Optional Feature:
Macro SCREEN_PAUSE_EN.
- Defined:
  - pause_btn sets pause_pend, latched only in PLAY or PAUSE.
  - At a boundary, PLAY -> PAUSE or PAUSE -> PLAY.
  - If coll_pend and pause_pend are both set in PLAY, collision wins: -> OVER, pause_pend cleared.
  - In PAUSE: game_en=0, and rgb is composited as in PLAY but shows over_rgb where over_valid (banner reused as "PAUSED").
- Undefined: state never takes value 3; pause_btn is ignored and may be left unconnected.

Test Plan:
- Reset release; pulse start_btn mid-frame -> state stays 0 until next vblank rise; then state=1, game_rst high exactly 1 cycle, game_en=1.
- In PLAY, pulse collision at hcount 500 -> state=2 at next boundary; game_en=0; with over_valid=1 and over_rgb=F00, rgb=F00 one cycle after the inputs.
- In OVER with HOLD_FRAMES=4: start_btn after 2 boundaries -> ignored, state stays 2; start_btn after 4 boundaries -> state=0 at next boundary.
- Compositing in START: start_valid=0, game_valid=1 -> rgb=4CF; start_valid=1, start_rgb=0F0 -> rgb=0F0 next cycle.
- Assert rst for 1 cycle while in OVER with start_pend set -> next cycle state=0, rgb=000, no game_rst; a following boundary causes no transition.
- SCREEN_PAUSE_EN: pause_btn and collision in the same frame while in PLAY -> state=2; pause_btn alone -> state=3, game_en=0; second pause_btn -> state=1.
